// File: rtl/alu_issue_controller_if.sv
// Issue/stall/completion bundle between the ID/EX pipeline register and the EX-stage ALU sequencer.
interface alu_issue_controller_if;
    logic        ISSUE_VALID;
    logic [4:0]  ALUOP;
    logic        ISSUE_READY;
    logic        FLUSH;
    logic [4:0]  ALU_SELECT;
    logic        BUSY;
    logic        RESULT_VALID;
    logic        ILLEGAL_OP;
    logic [31:0] BUSY_CYCLES;

    modport master (
        output ISSUE_VALID, ALUOP, FLUSH,
        input  ISSUE_READY, ALU_SELECT, BUSY, RESULT_VALID, ILLEGAL_OP, BUSY_CYCLES
    );

    modport slave (
        input  ISSUE_VALID, ALUOP, FLUSH,
        output ISSUE_READY, ALU_SELECT, BUSY, RESULT_VALID, ILLEGAL_OP, BUSY_CYCLES
    );
endinterface

// File: rtl/alu_issue_controller.sv
// Holds one ALU select for its class latency, stalls the pipe while it is in flight,
// and strobes completion when the ALU result should be captured.
//
// state | meaning
// IDLE  | no operation outstanding, issue accepted
// EXEC  | multi-cycle op in flight, CNT counts remaining cycles, issue blocked
// DONE  | result strobe cycle, back-to-back issue accepted
module alu_issue_controller #(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 34
) (
    input logic                   CLK,
    input logic                   RESET,
    alu_issue_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [5:0] MUL_L = MUL_CYCLES[5:0];
    localparam logic [5:0] DIV_L = DIV_CYCLES[5:0];

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [4:0]  sel_q, sel_d;
    logic        ill_q, ill_d;
    logic [31:0] bc_q, bc_d;
    logic [5:0]  lat;
    logic        ready;
    logic        accept;
    logic        busy;

    always_comb begin
        lat = 6'd1;
        if (bus.ALUOP >= 5'b01010 && bus.ALUOP <= 5'b01101) begin
            lat = MUL_L;
        end else if (bus.ALUOP >= 5'b01110 && bus.ALUOP <= 5'b10001) begin
            lat = DIV_L;
        end
    end

    // RESET is folded in so nothing is accepted while the block is held in reset
    assign ready  = (state_q != EXEC) & ~bus.FLUSH & RESET;
    assign accept = bus.ISSUE_VALID & ready;
    assign busy   = (state_q == EXEC) | (accept & (lat > 6'd1));

    assign bus.ISSUE_READY  = ready;
    assign bus.BUSY         = busy;
    assign bus.RESULT_VALID = (state_q == DONE) & ~bus.FLUSH;
    assign bus.ALU_SELECT   = sel_q;
    assign bus.ILLEGAL_OP   = ill_q;
    assign bus.BUSY_CYCLES  = bc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        ill_d   = ill_q;
        bc_d    = (busy && bc_q != 32'hFFFF_FFFF) ? bc_q + 32'd1 : bc_q;

        if (bus.FLUSH) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                EXEC: begin
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d = DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        sel_d = bus.ALUOP;
                        ill_d = (bus.ALUOP > 5'b10001);
                        if (lat == 6'd1) begin
                            state_d = DONE;
                            cnt_d   = 6'd0;
                        end else begin
                            state_d = EXEC;
                            cnt_d   = lat - 6'd1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            sel_q   <= 5'b00000;
            ill_q   <= 1'b0;
            bc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            ill_q   <= ill_d;
            bc_q    <= bc_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_controller.sv
// Self-checking bench: directed vector table, flush/reset sequences, then random issue against a timing model.
module tb_alu_issue_controller;
    localparam int MUL_CYC = 3;
    localparam int DIV_CYC = 34;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_controller_if bus();

    alu_issue_controller #(.MUL_CYCLES(MUL_CYC), .DIV_CYCLES(DIV_CYC)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic fl);
        bus.ISSUE_VALID = v;
        bus.ALUOP       = op;
        bus.FLUSH       = fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int lat_of(input logic [4:0] op);
        int v;
        v = int'(op);
        if (v >= 10 && v <= 13) return MUL_CYC;
        if (v >= 14 && v <= 17) return DIV_CYC;
        return 1;
    endfunction

    typedef struct {
        logic        v;
        logic [4:0]  op;
        logic        fl;
        logic        rdy;
        logic        busy;
        logic        rv;
        logic [4:0]  sel;
        logic        ill;
        logic [31:0] bc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [4:0] op, input logic fl, input logic rdy,
                       input logic busy, input logic rv, input logic [4:0] sel, input logic ill,
                       input logic [31:0] bc);
        vec_t e;
        e.v = v; e.op = op; e.fl = fl; e.rdy = rdy; e.busy = busy;
        e.rv = rv; e.sel = sel; e.ill = ill; e.bc = bc;
        vecs.push_back(e);
    endtask

    // random-phase model: ops described by accept cycle and completion cycle
    int          c;
    bit          active;
    int          acc_c, done_c;
    logic [4:0]  m_sel;
    logic        m_ill;
    longint      m_bc;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 1'b0);

        // reset values while held
        #2;
        check("rst.ready", 32'(bus.ISSUE_READY), 32'd0);
        check("rst.sel", 32'(bus.ALU_SELECT), 32'd0);
        check("rst.bc", bus.BUSY_CYCLES, 32'd0);
        check("rst.rv", 32'(bus.RESULT_VALID), 32'd0);

        //   v  op        fl rdy busy rv sel       ill bc
        add(0, 5'b00000, 0, 1, 0, 0, 5'b00000, 0, 0);
        add(1, 5'b00000, 0, 1, 0, 0, 5'b00000, 0, 0);
        add(1, 5'b00001, 0, 1, 0, 1, 5'b00000, 0, 0);
        add(1, 5'b00101, 0, 1, 0, 1, 5'b00001, 0, 0);
        add(0, 5'b00000, 0, 1, 0, 1, 5'b00101, 0, 0);
        add(0, 5'b00000, 0, 1, 0, 0, 5'b00101, 0, 0);
        add(1, 5'b10101, 0, 1, 0, 0, 5'b00101, 0, 0);
        add(1, 5'b00000, 0, 1, 0, 1, 5'b10101, 1, 0);
        add(0, 5'b00000, 0, 1, 0, 1, 5'b00000, 0, 0);
        add(0, 5'b00000, 0, 1, 0, 0, 5'b00000, 0, 0);
        add(1, 5'b01010, 0, 1, 1, 0, 5'b00000, 0, 0);
        add(1, 5'b01010, 0, 0, 1, 0, 5'b01010, 0, 1);
        add(0, 5'b00000, 0, 0, 1, 0, 5'b01010, 0, 2);
        add(0, 5'b00000, 0, 1, 0, 1, 5'b01010, 0, 3);
        add(0, 5'b00000, 0, 1, 0, 0, 5'b01010, 0, 3);

        do_reset();
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].op, vecs[i].fl);
            #1;
            check($sformatf("vec%0d.ready", i), 32'(bus.ISSUE_READY), 32'(vecs[i].rdy));
            check($sformatf("vec%0d.busy", i), 32'(bus.BUSY), 32'(vecs[i].busy));
            check($sformatf("vec%0d.rv", i), 32'(bus.RESULT_VALID), 32'(vecs[i].rv));
            check($sformatf("vec%0d.sel", i), 32'(bus.ALU_SELECT), 32'(vecs[i].sel));
            check($sformatf("vec%0d.ill", i), 32'(bus.ILLEGAL_OP), 32'(vecs[i].ill));
            check($sformatf("vec%0d.bc", i), bus.BUSY_CYCLES, vecs[i].bc);
        end

        // DIV cancelled by FLUSH at cycle 10, then a normal ADD
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k == 0)       drive(1'b1, 5'b01110, 1'b0);
            else if (k == 10) drive(1'b1, 5'b00000, 1'b1);
            else if (k == 11) drive(1'b1, 5'b00000, 1'b0);
            else              drive(1'b0, 5'b00000, 1'b0);
            #1;
            if (k <= 11) check($sformatf("flush.rv%0d", k), 32'(bus.RESULT_VALID), 32'd0);
            if (k == 0)  check("flush.busy_issue", 32'(bus.BUSY), 32'd1);
            if (k >= 1 && k <= 10) begin
                check($sformatf("flush.ready%0d", k), 32'(bus.ISSUE_READY), 32'd0);
                check($sformatf("flush.busy%0d", k), 32'(bus.BUSY), 32'd1);
                check($sformatf("flush.sel%0d", k), 32'(bus.ALU_SELECT), 32'b01110);
            end
            if (k == 11) begin
                check("flush.add_ready", 32'(bus.ISSUE_READY), 32'd1);
                check("flush.add_busy", 32'(bus.BUSY), 32'd0);
                check("flush.sel_hold", 32'(bus.ALU_SELECT), 32'b01110);
            end
            if (k == 12) begin
                check("flush.add_rv", 32'(bus.RESULT_VALID), 32'd1);
                check("flush.add_sel", 32'(bus.ALU_SELECT), 32'd0);
                check("flush.bc", bus.BUSY_CYCLES, 32'd14);
            end
        end

        // reset dropped mid-DIV
        @(negedge clk);
        drive(1'b1, 5'b01110, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("amid.ready", 32'(bus.ISSUE_READY), 32'd0);
        check("amid.busy", 32'(bus.BUSY), 32'd0);
        check("amid.rv", 32'(bus.RESULT_VALID), 32'd0);
        check("amid.sel", 32'(bus.ALU_SELECT), 32'd0);
        check("amid.ill", 32'(bus.ILLEGAL_OP), 32'd0);
        check("amid.bc", bus.BUSY_CYCLES, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("amid.post_rv%0d", k), 32'(bus.RESULT_VALID), 32'd0);
            check($sformatf("amid.post_busy%0d", k), 32'(bus.BUSY), 32'd0);
        end

        // random issue against the completion-time model
        do_reset();
        c = 0; active = 0; acc_c = 0; done_c = 0;
        m_sel = 5'd0; m_ill = 1'b0; m_bc = 0;
        for (int n = 0; n < 3000; n++) begin
            logic       v, fl;
            logic [4:0] op;
            int         r, L;
            bit         exec, in_done, e_rdy, e_acc, e_busy, e_rv;
            @(negedge clk);
            v  = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 24) == 0);
            r  = $urandom_range(0, 9);
            if (r < 4)       op = 5'($urandom_range(0, 9));
            else if (r < 7)  op = 5'($urandom_range(10, 13));
            else if (r < 8)  op = 5'($urandom_range(14, 17));
            else             op = 5'($urandom_range(18, 31));
            drive(v, op, fl);
            #1;
            L       = lat_of(op);
            exec    = active && c > acc_c && c < done_c;
            in_done = active && c == done_c;
            e_rdy   = !exec && !fl;
            e_acc   = v && e_rdy;
            e_busy  = exec || (e_acc && L > 1);
            e_rv    = in_done && !fl;
            check($sformatf("rnd%0d.ready", n), 32'(bus.ISSUE_READY), 32'(e_rdy));
            check($sformatf("rnd%0d.busy", n), 32'(bus.BUSY), 32'(e_busy));
            check($sformatf("rnd%0d.rv", n), 32'(bus.RESULT_VALID), 32'(e_rv));
            check($sformatf("rnd%0d.sel", n), 32'(bus.ALU_SELECT), 32'(m_sel));
            check($sformatf("rnd%0d.ill", n), 32'(bus.ILLEGAL_OP), 32'(m_ill));
            check($sformatf("rnd%0d.bc", n), bus.BUSY_CYCLES, 32'(m_bc));
            if (e_busy && m_bc < 64'hFFFF_FFFF) m_bc++;
            if (fl) begin
                active = 0;
            end else if (e_acc) begin
                active = 1;
                acc_c  = c;
                done_c = c + L;
                m_sel  = op;
                m_ill  = (int'(op) > 17);
            end else if (in_done) begin
                active = 0;
            end
            c++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue_controller.md
# alu_issue_controller

Sequences operations into the shared 32-bit ALU in the EX stage. It accepts one ALU operation at a time from the ID/EX pipeline register and classifies it as basic, multiply or divide/remainder. It holds the latched select on the ALU for that class's latency, stalls the pipeline while the operation is in flight, and pulses a completion strobe when the ALU output is to be captured.

## Interface
- MUL_CYCLES, default 3: ALU cycles for select 5'b01010–5'b01101; legal range 1–63.
- DIV_CYCLES, default 34: ALU cycles for select 5'b01110–5'b10001; legal range 1–63.
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous reset, active-low.
- ISSUE_VALID  in  1  an operation is presented on ALUOP.
- ALUOP  in  5  ALU select code of the presented operation.
- ISSUE_READY  out  1  controller accepts an issue this cycle (combinational).
- FLUSH  in  1  synchronous cancel of the in-flight operation (branch/jump redirect).
- ALU_SELECT  out  5  registered select driven to the ALU SELECT port.
- BUSY  out  1  stall request to the hazard unit; high while the operation is incomplete.
- RESULT_VALID  out  1  one-cycle strobe; the ALU RESULT is to be captured this cycle.
- ILLEGAL_OP  out  1  qualifies RESULT_VALID; high if the completed select was 5'b10010–5'b11111.
- BUSY_CYCLES  out  32  saturating count of cycles with BUSY high since reset.

## Operation
- States: IDLE, EXEC, DONE. Down-counter CNT is 6 bits.
- Latency L by class:
  - basic (5'b00000–5'b01001) and illegal (5'b10010–5'b11111): L = 1.
  - multiply: L = MUL_CYCLES.
  - divide/remainder: L = DIV_CYCLES.
- Accept rule: an issue is accepted on an edge where ISSUE_VALID & ISSUE_READY.
- ISSUE_READY = (state != EXEC) & ~FLUSH & RESET.
- On accept:
  - ALU_SELECT <= ALUOP.
  - ILLEGAL_OP <= (ALUOP > 5'b10001).
  - If L = 1, go to DONE. Otherwise go to EXEC with CNT <= L-1.
- EXEC:
  - If CNT == 1, go to DONE; otherwise CNT decrements.
  - ISSUE_VALID is ignored.
- DONE:
  - RESULT_VALID = 1.
  - A simultaneous accept starts the next operation back-to-back, using the same transitions as from IDLE.
  - With no accept, go to IDLE.
- IDLE: ALU_SELECT holds its last value.
- BUSY = (state == EXEC), or (accept this cycle with L > 1). BUSY is combinational, so the upstream stage stalls in the issue cycle.
- RESULT_VALID = (state == DONE) & ~FLUSH.
- FLUSH has the highest priority. On the edge where FLUSH is high:
  - Go to IDLE and clear CNT. No RESULT_VALID is produced for the cancelled operation.
  - No issue is accepted that cycle.
  - ALU_SELECT holds.
- BUSY_CYCLES increments on every edge where BUSY is high and stops at 32'hFFFFFFFF.
- A MUL_CYCLES or DIV_CYCLES value outside 1–63 is a configuration error; behaviour is undefined.

## Timing
- Reset (RESET low, asynchronous), all outputs:
  - state = IDLE, CNT = 0, ALU_SELECT = 5'b00000.
  - RESULT_VALID = 0, ILLEGAL_OP = 0, BUSY = 0, ISSUE_READY = 0, BUSY_CYCLES = 0.
  - Release is sampled at the next rising edge.
- Latency: with the accepting edge counted as edge 1, RESULT_VALID is high in the cycle following edge L.
  - Basic op: strobe in the cycle immediately after acceptance.
- Throughput:
  - Basic ops issued back-to-back complete one per cycle, with RESULT_VALID high continuously.
  - Multi-cycle ops: one per L cycles when issued from DONE.
- ALU_SELECT is stable from the edge after acceptance through the RESULT_VALID cycle inclusive.
- Reset asserted mid-EXEC: the operation is abandoned immediately and no strobe is produced.

## Test plan
- Reset release, then ADD (5'b00000) issued at edge 1:
  - ISSUE_READY = 1 before issue; BUSY = 0 throughout.
  - RESULT_VALID high in cycle 1 only; ALU_SELECT = 5'b00000.
- Back-to-back ADD, SUB, XOR issued on three consecutive edges:
  - RESULT_VALID high for three consecutive cycles.
  - ALU_SELECT steps 00000 → 00001 → 00101.
- MUL (5'b01010), MUL_CYCLES = 3:
  - BUSY high in the issue cycle and the next 2 cycles.
  - ISSUE_READY low during EXEC; RESULT_VALID in the cycle after edge 3.
  - BUSY_CYCLES = 3.
- DIV (5'b01110), DIV_CYCLES = 34, with FLUSH pulsed at cycle 10:
  - Returns to IDLE with no RESULT_VALID.
  - A following ADD is accepted one cycle after FLUSH and completes normally.
- Illegal select 5'b10101:
  - Completes after 1 cycle with RESULT_VALID = 1 and ILLEGAL_OP = 1.
  - The next ADD clears ILLEGAL_OP.
- RESET dropped mid-DIV:
  - All outputs take their reset values asynchronously.
  - No strobe after release.
